// File: rtl/bsg_mem_1rw_sync_mask_write_bit_arb.sv
// bsg_mem_1rw_sync_mask_write_bit_arb: zero-sweeps a 1rw masked RAM, then round-robin shares it between two requesters
module bsg_mem_1rw_sync_mask_write_bit_arb #(
  parameter int width_p = 8,
  parameter int els_p = 8,
  parameter bit init_zero_p = 1'b1,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [1:0]                 v_i,
  input  logic [1:0]                 w_i,
  input  logic [2*addr_width_lp-1:0] addr_i,
  input  logic [2*width_p-1:0]       data_i,
  input  logic [2*width_p-1:0]       w_mask_i,
  output logic [1:0]                 ready_o,
  output logic [width_p-1:0]         data_o,
  output logic [1:0]                 v_o,
  input  logic [1:0]                 yumi_i,
  output logic                       mem_v_o,
  output logic                       mem_w_o,
  output logic [addr_width_lp-1:0]   mem_addr_o,
  output logic [width_p-1:0]         mem_data_o,
  output logic [width_p-1:0]         mem_w_mask_o,
  input  logic [width_p-1:0]         mem_data_i
);
  typedef enum logic {INIT, RUN} state_e;
  state_e state;
  logic [addr_width_lp-1:0] cnt, g_addr;
  logic [width_p-1:0] head_data, skid_data, g_data, g_mask;
  logic rr_last, rd_pend, rd_owner, head_v, head_owner, skid_v, skid_owner;
  logic init, deq, hold, slot_free, gsel;
  logic [1:0] elig, grant;
  // A read may launch only if nothing captured is left after this cycle's dequeue;
  // the skid entry catches a read already in flight when the head is not consumed.
  always_comb begin
    init = (state == INIT) & ~reset_i;
    v_o = (head_v & ~reset_i) ? (head_owner ? 2'b10 : 2'b01) : 2'b00;
    data_o = head_data;
    deq = |(v_o & yumi_i);
    hold = head_v & ~deq;
    slot_free = ~skid_v & ~hold;
    elig = ((state == RUN) & ~reset_i) ? (v_i & (w_i | {2{slot_free}})) : 2'b00;
    grant = (&elig) ? (rr_last ? 2'b01 : 2'b10) : elig;
    gsel = grant[1];
    g_addr = gsel ? addr_i[2*addr_width_lp-1 -: addr_width_lp] : addr_i[addr_width_lp-1:0];
    g_data = gsel ? data_i[2*width_p-1 -: width_p] : data_i[width_p-1:0];
    g_mask = gsel ? w_mask_i[2*width_p-1 -: width_p] : w_mask_i[width_p-1:0];
    ready_o = grant;
    mem_v_o = init | (|grant);
    mem_w_o = init | ((|grant) & w_i[gsel]);
    mem_addr_o = init ? cnt : (|grant) ? g_addr : '0;
    mem_data_o = (|grant) ? g_data : '0;
    mem_w_mask_o = init ? '1 : (|grant) ? g_mask : '0;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= init_zero_p ? INIT : RUN;
      cnt <= '0;
      rr_last <= 1'b1;
      rd_pend <= 1'b0;
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      if (init) begin
        cnt <= cnt + 1'b1;
        if (cnt == addr_width_lp'(els_p - 1)) state <= RUN;
      end
      if (|grant) rr_last <= gsel;
      rd_pend <= (|grant) & ~w_i[gsel];
      rd_owner <= gsel;
      head_v <= hold | skid_v | rd_pend;
      skid_v <= hold ? (skid_v | rd_pend) : (skid_v & rd_pend);
    end
  end
  always_ff @(posedge clk_i) begin
    if (~hold) begin
      head_owner <= skid_v ? skid_owner : rd_owner;
      head_data <= skid_v ? skid_data : mem_data_i;
    end
    if (rd_pend & (hold | skid_v)) begin
      skid_owner <= rd_owner;
      skid_data <= mem_data_i;
    end
  end
  assert property (@(posedge clk_i) disable iff (reset_i) (yumi_i & ~v_o) == 2'b00);
endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_arb.sv
// tb_bsg_mem_1rw_sync_mask_write_bit_arb: vectors, directed sequences and random traffic vs a queue-based model
module tb_bsg_mem_1rw_sync_mask_write_bit_arb;
  localparam int N = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i = 1'b1, scramble = 1'b1;
  logic [1:0] v_i = '0, w_i = '0, yumi_i = '0, ready_o, v_o;
  logic [5:0] addr_i = '0;
  logic [15:0] data_i = '0, w_mask_i = '0;
  logic [7:0] data_o, mem_data_o, mem_w_mask_o, ram_q;
  logic [2:0] mem_addr_o;
  logic mem_v_o, mem_w_o;
  logic [7:0] ram [N];
  bsg_mem_1rw_sync_mask_write_bit_arb #(.width_p(8), .els_p(N), .init_zero_p(1'b1)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i), .data_i(data_i),
    .w_mask_i(w_mask_i), .ready_o(ready_o), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_w_mask_o(mem_w_mask_o), .mem_data_i(ram_q));
  always @(posedge clk) begin
    if (scramble) for (int i = 0; i < N; i++) ram[i] <= 8'($urandom);
    else if (mem_v_o) begin
      if (mem_w_o) ram[mem_addr_o] <= (ram[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
      else ram_q <= ram[mem_addr_o];
    end
  end
  typedef struct {logic o; logic [7:0] d;} rsp_t;
  rsp_t rq[$];
  rsp_t fl;
  logic fl_v = 1'b0, last = 1'b1;
  logic [7:0] shadow [N];
  int icnt = 0, total = 0, bad = 0;
  typedef struct {
    logic [1:0] v, w; logic [2:0] a0, a1; logic [7:0] d0, m0;
    logic [1:0] y, er, evo; logic [7:0] ed;
  } vec_t;
  vec_t tbl [15];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [1:0] mdl_vo();
    return (rq.size() == 0) ? 2'b00 : (rq[0].o ? 2'b10 : 2'b01);
  endfunction
  task automatic step(input logic rst, input logic [1:0] v, input logic [1:0] w,
                      input logic [2:0] a0, input logic [2:0] a1, input logic [7:0] d0,
                      input logic [7:0] m0, input logic [7:0] d1, input logic [7:0] m1,
                      input logic [1:0] y);
    logic [1:0] evo, elig, g;
    logic deq, cr;
    int gi;
    logic [2:0] ga;
    logic [7:0] gd, gm;
    @(negedge clk);
    reset_i = rst; v_i = v; w_i = w; addr_i = {a1, a0};
    data_i = {d1, d0}; w_mask_i = {m1, m0}; yumi_i = y;
    #1;
    if (rst) begin
      chk("rst_ready", 32'(ready_o), 0);
      chk("rst_vo", 32'(v_o), 0);
      rq.delete(); fl_v = 1'b0; icnt = 0; last = 1'b1;
      return;
    end
    evo = mdl_vo();
    chk("v_o", 32'(v_o), 32'(evo));
    if (evo != 2'b00) chk("data_o", 32'(data_o), 32'(rq[0].d));
    deq = (evo & y) != 2'b00;
    if (icnt < N) begin
      chk("init_ready", 32'(ready_o), 0);
      chk("init_mem_v", 32'(mem_v_o), 1);
      chk("init_mem_w", 32'(mem_w_o), 1);
      chk("init_addr", 32'(mem_addr_o), icnt);
      chk("init_data", 32'(mem_data_o), 0);
      chk("init_mask", 32'(mem_w_mask_o), 32'hff);
      shadow[icnt] = 8'h00;
      icnt++;
      return;
    end
    cr = (rq.size() - int'(deq)) == 0;
    elig = v & (w | {2{cr}});
    g = (elig == 2'b11) ? (last ? 2'b01 : 2'b10) : elig;
    chk("ready", 32'(ready_o), 32'(g));
    chk("mem_v", 32'(mem_v_o), 32'(|g));
    gi = int'(g[1]);
    ga = gi ? a1 : a0; gd = gi ? d1 : d0; gm = gi ? m1 : m0;
    if (g != 2'b00) begin
      chk("mem_w", 32'(mem_w_o), 32'(w[gi]));
      chk("mem_addr", 32'(mem_addr_o), 32'(ga));
      if (w[gi]) begin
        chk("mem_data", 32'(mem_data_o), 32'(gd));
        chk("mem_mask", 32'(mem_w_mask_o), 32'(gm));
      end
    end
    if (deq) void'(rq.pop_front());
    if (fl_v) rq.push_back(fl);
    fl_v = (g != 2'b00) && !w[gi];
    fl.o = g[1];
    fl.d = shadow[ga];
    if (g != 2'b00 && w[gi]) shadow[ga] = (shadow[ga] & ~gm) | (gd & gm);
    if (g != 2'b00) last = g[1];
  endtask
  task automatic idle(input logic [1:0] y);
    step(1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, y);
  endtask
  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || fl_v) && n < 10) begin
      idle(mdl_vo());
      n++;
    end
    chk("drain", rq.size() + int'(fl_v), 0);
  endtask
  task automatic read_all(input string tag, input int want_first);
    int k = 0, first = -1, lastg = -1;
    for (int c = 0; c < 30; c++) begin
      step(1'b0, (k < N) ? 2'b01 : 2'b00, 2'b00, 3'(k), 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, mdl_vo());
      if (v_o != 2'b00) chk({tag, "_zero"}, 32'(data_o), 0);
      if (k < N && ready_o[0]) begin
        if (first < 0) first = c;
        lastg = c;
        k++;
      end
    end
    chk({tag, "_first_grant"}, first, want_first);
    chk({tag, "_stream_len"}, lastg - first, N - 1);
    chk({tag, "_reads"}, k, N);
  endtask
  initial begin
    tbl = '{
      '{2'b01, 2'b01, 3'd3, 3'd0, 8'hff, 8'h0f, 2'b00, 2'b01, 2'b00, 8'h00},
      '{2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b00, 2'b01, 2'b00, 8'h00},
      '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00},
      '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b01, 2'b00, 2'b01, 8'h0f},
      '{2'b10, 2'b00, 3'd0, 3'd3, 8'h00, 8'h00, 2'b00, 2'b10, 2'b00, 8'h00},
      '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00},
      '{2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 8'h0f},
      '{2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 8'h0f},
      '{2'b01, 2'b01, 3'd5, 3'd0, 8'haa, 8'hff, 2'b00, 2'b01, 2'b10, 8'h0f},
      '{2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 8'h0f},
      '{2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 8'h0f},
      '{2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b10, 2'b01, 2'b10, 8'h0f},
      '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00},
      '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b01, 2'b00, 2'b01, 8'h0f},
      '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00}};
    step(1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    step(1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    scramble = 1'b0;
    // sweep length and zeroed contents, read streaming at one grant per cycle
    read_all("s1", N);
    drain();
    // both requesters writing every cycle alternate, starting with requester 0
    step(1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    for (int i = 0; i < N; i++) idle(2'b00);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'b11, 2'b11, 3'(i), 3'(7 - i), 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
      chk("alt_grant", 32'(ready_o), (i % 2) ? 32'd2 : 32'd1);
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, tbl[i].v, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].m0, 8'h00, 8'h00, tbl[i].y);
      chk($sformatf("tbl%0d_ready", i), 32'(ready_o), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_vo", i), 32'(v_o), 32'(tbl[i].evo));
      if (tbl[i].evo != 2'b00) chk($sformatf("tbl%0d_data", i), 32'(data_o), 32'(tbl[i].ed));
    end
    for (int i = 0; i < 1500; i++)
      step(1'b0, 2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom), mdl_vo() & (($urandom % 4 != 0) ? 2'b11 : 2'b00));
    drain();
    // reset right after a read grant discards it and re-zeroes the RAM
    step(1'b0, 2'b01, 2'b00, 3'd5, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    chk("s6_grant", 32'(ready_o), 1);
    step(1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    for (int i = 0; i < N; i++) begin
      idle(2'b00);
      chk("s6_no_vo", 32'(v_o), 0);
    end
    read_all("s6", 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
